// File: rtl/spi_pkg.sv
// Shared SPI definitions: FSM states, frame size and the idle transmit byte
// used by both the SPI master and the slave endpoint.
package spi_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  localparam int unsigned SPI_BITS = 8;
  localparam int unsigned SPI_CNT_W = $clog2(SPI_BITS);
  localparam logic [SPI_BITS-1:0] SPI_DEFAULT_TX = 8'hFF;

  // True when the counter points at the last bit of a frame.
  function automatic logic is_last_bit(input logic [SPI_CNT_W-1:0] cnt);
    return cnt == SPI_CNT_W'(SPI_BITS - 1);
  endfunction

endpackage

// File: rtl/spi_pin_sync.sv
// Multi-flop synchroniser for one asynchronous SPI pin, with rising/falling
// edge strobes taken from the last two synchroniser stages.
module spi_pin_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock_in,
  input  logic rs,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  // sync_r[SYNC_STAGES-1] is the synchronised level; the top flop holds its previous value.
  logic [SYNC_STAGES:0] sync_r;

  // Shift the raw pin through the synchroniser chain.
  always_ff @(posedge clock_in) begin
    if (rs) begin
      sync_r <= '0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-1:0], pin};
    end
  end

  assign level = sync_r[SYNC_STAGES-1];
  assign rise  = sync_r[SYNC_STAGES-1] & ~sync_r[SYNC_STAGES];
  assign fall  = ~sync_r[SYNC_STAGES-1] & sync_r[SYNC_STAGES];

endmodule

// File: rtl/spi_slave_if.sv
// SPI mode-0 slave endpoint: oversampled pins, byte deserialiser with rx
// strobe, and a one-entry tx buffer feeding the miso serialiser.
module spi_slave_if
  import spi_pkg::*;
#(
  parameter int               SYNC_STAGES = 2,
  parameter logic [SPI_BITS-1:0] DEFAULT_TX = SPI_DEFAULT_TX
) (
  input  logic                clock_in,
  input  logic                rs,
  input  logic                sclk,
  input  logic                mosi,
  input  logic                cs_in,
  output logic                miso,
  input  logic [SPI_BITS-1:0] tx_data,
  input  logic                tx_valid,
  output logic                tx_ready,
  output logic [SPI_BITS-1:0] rx_data,
  output logic                rx_valid,
  output logic                tx_underrun,
  output logic                busy
);

  logic sclk_lvl_s, sclk_rise_s, sclk_fall_s;
  logic mosi_lvl_s, mosi_rise_s, mosi_fall_s;
  logic cs_lvl_s, cs_rise_s, cs_fall_s;
  logic unused_pins_s;

  state_e                state_r, state_nxt_s;
  logic                  busy_r;
  logic                  start_s, abort_s, load_s, shift_s, sample_s;
  logic [SPI_BITS-1:0]   load_byte_s;
  logic                  load_default_s;
  logic [SPI_BITS-1:0]   buf_r, tx_shift_r, rx_shift_r, rx_data_r;
  logic                  tx_ready_r, miso_r, underrun_r, rx_valid_r, byte_done_r;
  logic [SPI_CNT_W-1:0]  bit_cnt_r;

  spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
    .clock_in(clock_in), .rs(rs), .pin(sclk),
    .level(sclk_lvl_s), .rise(sclk_rise_s), .fall(sclk_fall_s)
  );
  spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mosi (
    .clock_in(clock_in), .rs(rs), .pin(mosi),
    .level(mosi_lvl_s), .rise(mosi_rise_s), .fall(mosi_fall_s)
  );
  spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_cs (
    .clock_in(clock_in), .rs(rs), .pin(cs_in),
    .level(cs_lvl_s), .rise(cs_rise_s), .fall(cs_fall_s)
  );

  assign unused_pins_s = ^{sclk_lvl_s, mosi_rise_s, mosi_fall_s, cs_lvl_s};

  // State register and registered busy flag.
  always_ff @(posedge clock_in) begin
    if (rs) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      busy_r  <= (state_nxt_s == SHIFT);
    end
  end

  // Next-state logic: cs low opens a transfer window, cs high closes it.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE:    if (cs_fall_s) state_nxt_s = SHIFT; else state_nxt_s = IDLE;
      SHIFT:   if (cs_rise_s) state_nxt_s = IDLE;  else state_nxt_s = SHIFT;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Datapath strobes; cs rise wins over any coincident sclk edge.
  always_comb begin
    start_s  = 1'b0;
    abort_s  = 1'b0;
    load_s   = 1'b0;
    shift_s  = 1'b0;
    sample_s = 1'b0;
    case (state_r)
      IDLE: begin
        start_s = cs_fall_s;
        load_s  = cs_fall_s;
      end
      SHIFT: begin
        if (cs_rise_s) begin
          abort_s = 1'b1;
        end else begin
          sample_s = sclk_rise_s;
          load_s   = sclk_fall_s & byte_done_r;
          shift_s  = sclk_fall_s & ~byte_done_r;
        end
      end
      default: abort_s = 1'b1;
    endcase
  end

  // Next tx byte: buffered byte first, then a same-cycle bypass, else the idle pattern.
  always_comb begin
    load_default_s = 1'b0;
    if (!tx_ready_r) begin
      load_byte_s = buf_r;
    end else if (tx_valid) begin
      load_byte_s = tx_data;
    end else begin
      load_byte_s    = DEFAULT_TX;
      load_default_s = 1'b1;
    end
  end

  // One-entry tx buffer; a write that coincides with a load goes straight to the shifter.
  always_ff @(posedge clock_in) begin
    if (rs) begin
      buf_r      <= '0;
      tx_ready_r <= 1'b1;
    end else if (load_s && !tx_ready_r) begin
      tx_ready_r <= 1'b1;
    end else if (tx_valid && tx_ready_r && !load_s) begin
      buf_r      <= tx_data;
      tx_ready_r <= 1'b0;
    end
  end

  // Tx serialiser: miso changes only on load, sclk fall, or transfer end.
  always_ff @(posedge clock_in) begin
    if (rs) begin
      tx_shift_r <= '0;
      miso_r     <= 1'b0;
      underrun_r <= 1'b0;
    end else begin
      underrun_r <= load_s & load_default_s;
      if (abort_s) begin
        miso_r <= 1'b0;
      end else if (load_s) begin
        tx_shift_r <= load_byte_s;
        miso_r     <= load_byte_s[SPI_BITS-1];
      end else if (shift_s) begin
        tx_shift_r <= {tx_shift_r[SPI_BITS-2:0], 1'b0};
        miso_r     <= tx_shift_r[SPI_BITS-2];
      end
    end
  end

  // Rx deserialiser and bit counter; partial bytes are dropped on cs rise.
  always_ff @(posedge clock_in) begin
    if (rs) begin
      rx_shift_r  <= '0;
      rx_data_r   <= '0;
      rx_valid_r  <= 1'b0;
      bit_cnt_r   <= '0;
      byte_done_r <= 1'b0;
    end else begin
      rx_valid_r <= 1'b0;
      if (abort_s || start_s) begin
        rx_shift_r  <= '0;
        bit_cnt_r   <= '0;
        byte_done_r <= 1'b0;
      end else if (sample_s) begin
        rx_shift_r <= {rx_shift_r[SPI_BITS-2:0], mosi_lvl_s};
        if (is_last_bit(bit_cnt_r)) begin
          rx_data_r   <= {rx_shift_r[SPI_BITS-2:0], mosi_lvl_s};
          rx_valid_r  <= 1'b1;
          bit_cnt_r   <= '0;
          byte_done_r <= 1'b1;
        end else begin
          bit_cnt_r <= bit_cnt_r + SPI_CNT_W'(1);
        end
      end else if (load_s) begin
        byte_done_r <= 1'b0;
      end
    end
  end

  assign miso        = miso_r;
  assign tx_ready    = tx_ready_r;
  assign rx_data     = rx_data_r;
  assign rx_valid    = rx_valid_r;
  assign tx_underrun = underrun_r;
  assign busy        = busy_r;

endmodule

// File: tb/tb_spi_slave_if.sv
// Directed bench for spi_slave_if: a behavioural mode-0 master drives the
// pins and each task checks its scenario against hand-computed values.
module tb_spi_slave_if;

  logic       clock_in = 1'b0;
  logic       rs, sclk, mosi, cs_in, miso;
  logic [7:0] tx_data, rx_data;
  logic       tx_valid, tx_ready, rx_valid, tx_underrun, busy;

  int n_vec = 0;
  int n_err = 0;
  int rx_cnt = 0;
  int under_cnt = 0;
  logic [7:0] rx_hist [0:63];

  always #5 clock_in = ~clock_in;

  spi_slave_if #(.SYNC_STAGES(2), .DEFAULT_TX(8'hFF)) dut (
    .clock_in(clock_in), .rs(rs), .sclk(sclk), .mosi(mosi), .cs_in(cs_in),
    .miso(miso), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .tx_underrun(tx_underrun), .busy(busy)
  );

  // Record every rx strobe and underrun strobe, one count per high cycle.
  always @(negedge clock_in) begin
    if (rx_valid === 1'b1) begin
      rx_hist[rx_cnt] <= rx_data;
      rx_cnt <= rx_cnt + 1;
    end
    if (tx_underrun === 1'b1) under_cnt <= under_cnt + 1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: run did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clock_in);
    #1;
  endtask

  // Mode-0 master: mosi set while sclk low, miso sampled on sclk rise, 16-cycle period.
  task automatic spi_xfer(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
    mi = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      mosi = mo[7-i];
      cyc(8);
      sclk = 1'b1;
      mi = {mi[6:0], miso};
      cyc(8);
      sclk = 1'b0;
    end
  endtask

  task automatic frame(input logic [7:0] mo, output logic [7:0] mi);
    cs_in = 1'b0;
    cyc(8);
    spi_xfer(mo, 8, mi);
    cyc(8);
    cs_in = 1'b1;
    cyc(8);
  endtask

  task automatic write_tx(input logic [7:0] d);
    tx_data = d;
    tx_valid = 1'b1;
    cyc(1);
    tx_valid = 1'b0;
  endtask

  task automatic test_reset;
    rs = 1'b1; cs_in = 1'b1; sclk = 1'b0; mosi = 1'b0; tx_valid = 1'b0; tx_data = 8'h00;
    cyc(3);
    n_vec++; if (miso !== 1'b0) begin n_err++; $display("FAIL reset_miso: got %b expected 0", miso); end
    n_vec++; if (rx_data !== 8'h00) begin n_err++; $display("FAIL reset_rx_data: got %h expected 00", rx_data); end
    n_vec++; if (rx_valid !== 1'b0) begin n_err++; $display("FAIL reset_rx_valid: got %b expected 0", rx_valid); end
    n_vec++; if (tx_underrun !== 1'b0) begin n_err++; $display("FAIL reset_underrun: got %b expected 0", tx_underrun); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_vec++; if (tx_ready !== 1'b1) begin n_err++; $display("FAIL reset_tx_ready: got %b expected 1", tx_ready); end
    rs = 1'b0;
    cyc(4);
  endtask

  task automatic test_preload_frame;
    int base;
    logic [7:0] mi;
    write_tx(8'h3C);
    n_vec++; if (tx_ready !== 1'b0) begin n_err++; $display("FAIL preload_ready: got %b expected 0", tx_ready); end
    base = rx_cnt;
    frame(8'hD5, mi);
    n_vec++; if (rx_cnt - base !== 1) begin n_err++; $display("FAIL preload_rx_pulses: got %0d expected 1", rx_cnt - base); end
    n_vec++; if (rx_hist[base] !== 8'hD5) begin n_err++; $display("FAIL preload_rx_byte: got %h expected d5", rx_hist[base]); end
    n_vec++; if (rx_data !== 8'hD5) begin n_err++; $display("FAIL preload_rx_held: got %h expected d5", rx_data); end
    n_vec++; if (mi !== 8'h3C) begin n_err++; $display("FAIL preload_miso: got %h expected 3c", mi); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL preload_busy_end: got %b expected 0", busy); end
  endtask

  task automatic test_underrun;
    int base, base_u;
    logic [7:0] mi;
    base = rx_cnt;
    base_u = under_cnt;
    cs_in = 1'b0;
    cyc(8);
    n_vec++; if (under_cnt - base_u !== 1) begin n_err++; $display("FAIL underrun_pulse: got %0d expected 1", under_cnt - base_u); end
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL underrun_busy: got %b expected 1", busy); end
    spi_xfer(8'hA5, 8, mi);
    cyc(8);
    cs_in = 1'b1;
    cyc(8);
    n_vec++; if (mi !== 8'hFF) begin n_err++; $display("FAIL underrun_miso: got %h expected ff", mi); end
    n_vec++; if (rx_cnt - base !== 1) begin n_err++; $display("FAIL underrun_rx_pulses: got %0d expected 1", rx_cnt - base); end
    n_vec++; if (rx_hist[base] !== 8'hA5) begin n_err++; $display("FAIL underrun_rx_byte: got %h expected a5", rx_hist[base]); end
  endtask

  task automatic test_back_to_back;
    int base;
    logic [7:0] mi1, mi2;
    write_tx(8'h81);
    n_vec++; if (tx_ready !== 1'b0) begin n_err++; $display("FAIL b2b_ready_preload: got %b expected 0", tx_ready); end
    base = rx_cnt;
    cs_in = 1'b0;
    cyc(8);
    n_vec++; if (tx_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready_loaded: got %b expected 1", tx_ready); end
    write_tx(8'h7E);
    n_vec++; if (tx_ready !== 1'b0) begin n_err++; $display("FAIL b2b_ready_second: got %b expected 0", tx_ready); end
    spi_xfer(8'h12, 8, mi1);
    cyc(8);
    n_vec++; if (tx_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready_reload: got %b expected 1", tx_ready); end
    spi_xfer(8'h34, 8, mi2);
    cyc(8);
    cs_in = 1'b1;
    cyc(8);
    n_vec++; if (rx_cnt - base !== 2) begin n_err++; $display("FAIL b2b_rx_pulses: got %0d expected 2", rx_cnt - base); end
    n_vec++; if (rx_hist[base] !== 8'h12) begin n_err++; $display("FAIL b2b_rx_first: got %h expected 12", rx_hist[base]); end
    n_vec++; if (rx_hist[base+1] !== 8'h34) begin n_err++; $display("FAIL b2b_rx_second: got %h expected 34", rx_hist[base+1]); end
    n_vec++; if (mi1 !== 8'h81) begin n_err++; $display("FAIL b2b_miso_first: got %h expected 81", mi1); end
    n_vec++; if (mi2 !== 8'h7E) begin n_err++; $display("FAIL b2b_miso_second: got %h expected 7e", mi2); end
  endtask

  task automatic test_abort;
    int base;
    logic [7:0] mi;
    base = rx_cnt;
    cs_in = 1'b0;
    cyc(8);
    spi_xfer(8'hF0, 5, mi);
    cyc(8);
    cs_in = 1'b1;
    cyc(8);
    n_vec++; if (rx_cnt !== base) begin n_err++; $display("FAIL abort_no_rx: got %0d expected %0d", rx_cnt, base); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL abort_busy: got %b expected 0", busy); end
    n_vec++; if (miso !== 1'b0) begin n_err++; $display("FAIL abort_miso: got %b expected 0", miso); end
    frame(8'h0F, mi);
    n_vec++; if (rx_cnt - base !== 1) begin n_err++; $display("FAIL abort_next_pulses: got %0d expected 1", rx_cnt - base); end
    n_vec++; if (rx_hist[base] !== 8'h0F) begin n_err++; $display("FAIL abort_next_byte: got %h expected 0f", rx_hist[base]); end
  endtask

  task automatic test_reset_mid;
    int base;
    logic [7:0] mi;
    base = rx_cnt;
    cs_in = 1'b0;
    cyc(8);
    write_tx(8'h42);
    n_vec++; if (tx_ready !== 1'b0) begin n_err++; $display("FAIL rsmid_buffer_full: got %b expected 0", tx_ready); end
    spi_xfer(8'hA0, 3, mi);
    rs = 1'b1;
    cyc(1);
    rs = 1'b0;
    n_vec++; if (miso !== 1'b0) begin n_err++; $display("FAIL rsmid_miso: got %b expected 0", miso); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rsmid_busy: got %b expected 0", busy); end
    n_vec++; if (tx_ready !== 1'b1) begin n_err++; $display("FAIL rsmid_flush: got %b expected 1", tx_ready); end
    n_vec++; if (rx_data !== 8'h00) begin n_err++; $display("FAIL rsmid_rx_data: got %h expected 00", rx_data); end
    n_vec++; if (rx_valid !== 1'b0) begin n_err++; $display("FAIL rsmid_rx_valid: got %b expected 0", rx_valid); end
    spi_xfer(8'hFF, 5, mi);
    cyc(8);
    n_vec++; if (rx_cnt !== base) begin n_err++; $display("FAIL rsmid_ignored: got %0d expected %0d", rx_cnt, base); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rsmid_stay_idle: got %b expected 0", busy); end
    cs_in = 1'b1;
    cyc(8);
    frame(8'h55, mi);
    n_vec++; if (rx_cnt - base !== 1) begin n_err++; $display("FAIL rsmid_next_pulses: got %0d expected 1", rx_cnt - base); end
    n_vec++; if (rx_hist[base] !== 8'h55) begin n_err++; $display("FAIL rsmid_next_byte: got %h expected 55", rx_hist[base]); end
  endtask

  // cs fall reaches the FSM after SYNC_STAGES+1 edges; tx_valid is raised only in that cycle.
  task automatic test_bypass;
    int base_u;
    logic [7:0] mi;
    n_vec++; if (tx_ready !== 1'b1) begin n_err++; $display("FAIL bypass_start_ready: got %b expected 1", tx_ready); end
    base_u = under_cnt;
    cs_in = 1'b0;
    cyc(2);
    tx_data = 8'h99;
    tx_valid = 1'b1;
    n_vec++; if (tx_ready !== 1'b1) begin n_err++; $display("FAIL bypass_ready_handshake: got %b expected 1", tx_ready); end
    cyc(1);
    tx_valid = 1'b0;
    n_vec++; if (tx_ready !== 1'b1) begin n_err++; $display("FAIL bypass_buffer_empty: got %b expected 1", tx_ready); end
    cyc(6);
    n_vec++; if (under_cnt !== base_u) begin n_err++; $display("FAIL bypass_no_underrun: got %0d expected %0d", under_cnt, base_u); end
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL bypass_busy: got %b expected 1", busy); end
    spi_xfer(8'h3C, 8, mi);
    cyc(8);
    cs_in = 1'b1;
    cyc(8);
    n_vec++; if (mi !== 8'h99) begin n_err++; $display("FAIL bypass_miso: got %h expected 99", mi); end
  endtask

  initial begin
    test_reset();
    test_preload_frame();
    test_underrun();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    test_bypass();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
